// File: rtl/uart_transmitter_if.sv
// Byte-stream handshake into the UART transmitter.
// master drives tx_data/tx_valid; slave returns tx_ready.
interface uart_transmitter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: small byte FIFO feeding an 8N1-style serializer.
// Ports: clk, reset, s_if (tx_data/tx_valid/tx_ready), tx, tx_busy, tx_done, fifo_count.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_transmitter_if.slave           s_if,
  output logic                        tx,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW =
    (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PTR_ONE   = CW'(1);
  localparam logic          P_EN      = (PARITY_EN != 0);
  localparam logic          P_ODD     = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        r_state;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [CW-1:0] r_wptr;
  logic [CW-1:0] r_rptr;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic          r_tx;
  logic          r_busy;
  logic          r_done;

  logic [CW-1:0] w_count;
  logic [7:0]    w_head;
  logic          w_ready;
  logic          w_push;
  logic          w_nonempty;
  logic          w_bit_end;
  logic          w_stop_end;
  logic          w_pop;

  // Pointers carry one extra wrap bit so full and empty differ.
  assign w_count    = r_wptr - r_rptr;
  assign w_ready    = (w_count < DEPTH_C);
  assign w_nonempty = (w_count != '0);
  assign w_push     = s_if.tx_valid && w_ready;
  assign w_head     = r_mem[r_rptr[AW-1:0]];

  assign w_bit_end  = (r_baud == BAUD_LAST);
  assign w_stop_end = (r_state == STOP) && w_bit_end &&
                      (r_bit == STOP_LAST);
  // Pop from idle, or straight out of the last stop bit.
  assign w_pop      = w_nonempty &&
                      ((r_state == IDLE) || w_stop_end);

  assign s_if.tx_ready = w_ready;
  assign fifo_count    = w_count;
  assign tx            = r_tx;
  assign tx_busy       = r_busy;
  assign tx_done       = r_done;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= s_if.tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_nonempty) begin
            r_shift <= w_head;
            r_par   <= (^w_head) ^ P_ODD;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_bit <= '0;
              if (P_EN) begin
                r_tx    <= r_par;
                r_state <= PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= STOP;
              end
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_state <= STOP;
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == STOP_LAST) begin
              r_done <= 1'b1;
              r_bit  <= '0;
              if (w_nonempty) begin
                r_shift <= w_head;
                r_par   <= (^w_head) ^ P_ODD;
                r_tx    <= 1'b0;
                r_state <= START;
              end else begin
                r_tx    <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
